// File: rtl/amo_pkg.sv
// Shared types and constants for the memory-side atomic responder and its ALU.
package amo_pkg;

  typedef enum logic [3:0] {
    OpLoad  = 4'd0,
    OpStore = 4'd1,
    OpLr    = 4'd2,
    OpSc    = 4'd3,
    OpSwap  = 4'd4,
    OpAdd   = 4'd5,
    OpXor   = 4'd6,
    OpAnd   = 4'd7,
    OpOr    = 4'd8,
    OpMin   = 4'd9,
    OpMax   = 4'd10,
    OpMinu  = 4'd11,
    OpMaxu  = 4'd12
  } amo_req_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapture,
    StWrite,
    StResp
  } amo_rsp_state_e;

  localparam int unsigned ScSuccess = 0;
  localparam int unsigned ScFail    = 1;

  // Encodings 13..15 are not defined and behave as a plain load.
  function automatic amo_req_op_e decode_op(input logic [3:0] raw);
    return (raw > 4'd12) ? OpLoad : amo_req_op_e'(raw);
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO new-value computation; equal compare operands resolve to rs2.
module amo_alu
  import amo_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  amo_req_op_e     op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] result_o
);

  always_comb begin
    result_o = rs2_i;
    case (op_i)
      OpSwap:  result_o = rs2_i;
      OpAdd:   result_o = old_i + rs2_i;
      OpXor:   result_o = old_i ^ rs2_i;
      OpAnd:   result_o = old_i & rs2_i;
      OpOr:    result_o = old_i | rs2_i;
      OpMin:   result_o = ($signed(old_i) < $signed(rs2_i)) ? old_i : rs2_i;
      OpMax:   result_o = ($signed(old_i) > $signed(rs2_i)) ? old_i : rs2_i;
      OpMinu:  result_o = (old_i < rs2_i) ? old_i : rs2_i;
      OpMaxu:  result_o = (old_i > rs2_i) ? old_i : rs2_i;
      default: result_o = rs2_i;
    endcase
  end

endmodule

// File: rtl/amo_mem_responder.sv
// Single-outstanding atomic responder in front of a 1-cycle-latency single-port BRAM.
module amo_mem_responder
  import amo_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [3:0]                i_req_op,
  input  logic [XLEN-1:0]           i_req_addr,
  input  logic [XLEN-1:0]           i_req_wdata,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [XLEN-1:0]           o_rsp_data,
  output logic                      o_rsp_err,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                      o_mem_we,
  output logic [XLEN-1:0]           o_mem_wdata,
  input  logic [XLEN-1:0]           i_mem_rdata
);

  amo_rsp_state_e  state_q, state_d;
  amo_req_op_e     op_q, op_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            resv_valid_q, resv_valid_d;
  logic [XLEN-3:0] resv_addr_q, resv_addr_d;

  amo_req_op_e     req_op;
  logic            accept;
  logic            is_amo;
  logic [XLEN-1:0] alu_result;

  assign req_op = decode_op(i_req_op);
  assign accept = i_req_valid && o_req_ready;
  assign is_amo = !(op_q inside {OpLoad, OpStore, OpLr, OpSc});

  amo_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op_i    (op_q),
    .old_i   (old_q),
    .rs2_i   (wdata_q),
    .result_o(alu_result)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    old_d        = old_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d      = req_op;
          addr_d    = i_req_addr;
          wdata_d   = i_req_wdata;
          rsp_err_d = 1'b0;
          if (i_req_addr[1:0] != 2'b00) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = StResp;
          end else begin
            case (req_op)
              OpStore: state_d = StWrite;
              OpSc: begin
                resv_valid_d = 1'b0;
                if (resv_valid_q && (resv_addr_q == i_req_addr[XLEN-1:2])) begin
                  state_d = StWrite;
                end else begin
                  rsp_data_d = XLEN'(ScFail);
                  state_d    = StResp;
                end
              end
              default: state_d = StRead;
            endcase
          end
        end
      end
      StRead: state_d = StCapture;
      StCapture: begin
        old_d = i_mem_rdata;
        if (op_q == OpLoad || op_q == OpLr) begin
          rsp_data_d = i_mem_rdata;
          state_d    = StResp;
          if (op_q == OpLr) begin
            resv_valid_d = 1'b1;
            resv_addr_d  = addr_q[XLEN-1:2];
          end
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        rsp_data_d = is_amo ? old_q : XLEN'(ScSuccess);
        // Any write to the reserved word breaks the reservation.
        if (resv_valid_q && (resv_addr_q == addr_q[XLEN-1:2])) begin
          resv_valid_d = 1'b0;
        end
        state_d = StResp;
      end
      StResp: begin
        if (i_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      op_q         <= OpLoad;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

  // Handshake and write strobe are gated by reset so they drop in the cycle reset is sampled.
  assign o_req_ready = (state_q == StIdle) && !i_rst;
  assign o_rsp_valid = (state_q == StResp) && !i_rst;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_mem_addr  = (state_q != StIdle) ? addr_q[MEM_ADDR_WIDTH+1:2] : '0;
  assign o_mem_we    = (state_q == StWrite) && !i_rst;
  assign o_mem_wdata = (state_q == StWrite) ? (is_amo ? alu_result : wdata_q) : '0;

endmodule
